// File: rtl/ft_telem_pkg.sv
// ft_telem_pkg: shared definitions for the FT telemetry stream multiplexer.
//   - default sync byte placed in the top byte of every header word
//   - state encoding for the framing/loopback controller
//   - header field widths and the packet-to-bus word count helper
package ft_telem_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam int unsigned SEQ_W         = 4;
    localparam int unsigned CH_FIELD_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_LOOP    = 2'd3
    } state_e;

    // Number of bus words needed to carry one packet (ceiling division).
    function automatic int unsigned calc_words(input int unsigned pkt_w,
                                               input int unsigned bus_w);
        return (pkt_w + bus_w - 1) / bus_w;
    endfunction

endpackage

// File: rtl/ft_telem_stream_mux_rr_arbiter.sv
// rr_arbiter: round-robin arbiter.
//   clk, rst  : clock and synchronous active-high reset
//   req       : request vector
//   accept    : the current grant is taken this cycle; pointer moves to it
//   gnt       : one-hot grant (combinational)
//   gnt_idx   : index of the granted requester
//   gnt_any   : some requester is granted
// The search starts one above the last accepted index and wraps, so after
// reset (pointer = NUM_REQ-1) requester 0 has highest priority.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    int unsigned      idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = 32'(ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && gnt_any) begin
            ptr_d = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ft_telem_stream_mux.sv
// ft_telem_stream_mux: round-robin telemetry packet framer onto the FT bus,
// with a run-time selectable legacy host loopback path.
//   clk_128M, rst_128M         : clock, synchronous active-high reset
//   mode                       : 0 = loopback, 1 = telemetry
//   in_data/in_valid/in_ready  : NUM_CH packet channels, one-hot accept pulse
//   ui_dout*/ui_dout_get       : host->FPGA side of the ft block
//   ui_din*/ui_din_full        : FPGA->host side of the ft block
//   pkt_count                  : telemetry packets fully sent (wraps)
//   busy                       : header or payload in flight
// Frame: one header {SYNC_BYTE, seq, ch} followed by WORDS payload words,
// MSB first, last word zero-padded in its low bits.
import ft_telem_pkg::*;

module ft_telem_stream_mux #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned PKT_W     = 88,
    parameter int unsigned BUS_W     = 16,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic                    clk_128M,
    input  logic                    rst_128M,
    input  logic                    mode,
    input  logic [NUM_CH*PKT_W-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [BUS_W-1:0]        ui_dout,
    input  logic [BUS_W/8-1:0]      ui_dout_be,
    input  logic                    ui_dout_empty,
    output logic                    ui_dout_get,
    output logic [BUS_W-1:0]        ui_din,
    output logic [BUS_W/8-1:0]      ui_din_be,
    output logic                    ui_din_valid,
    input  logic                    ui_din_full,
    output logic [31:0]             pkt_count,
    output logic                    busy
);

    localparam int unsigned WORDS  = calc_words(PKT_W, BUS_W);
    localparam int unsigned SH_W   = WORDS * BUS_W;
    localparam int unsigned WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e                  state_q, state_d;
    logic [SEQ_W-1:0]        seq_q, seq_d;
    logic [SEQ_W-1:0]        hdr_seq_q, hdr_seq_d;
    logic [CH_FIELD_W-1:0]   ch_q, ch_d;
    logic [SH_W-1:0]         sh_q, sh_d;
    logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
    logic [31:0]             pkt_q, pkt_d;

    logic                    arb_en;
    logic [NUM_CH-1:0]       gnt;
    logic [CH_W-1:0]         gnt_idx;
    logic                    gnt_any;
    logic [PKT_W-1:0]        pkt_sel;
    logic [BUS_W-1:0]        hdr_word;
    logic                    consume;

    // Requests are masked outside telemetry IDLE and during reset, so a
    // grant always means the packet is accepted in this cycle.
    assign arb_en = (state_q == ST_IDLE) && mode && !rst_128M;

    rr_arbiter #(
        .NUM_REQ (NUM_CH)
    ) u_arb (
        .clk     (clk_128M),
        .rst     (rst_128M),
        .req     (in_valid & {NUM_CH{arb_en}}),
        .accept  (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign in_ready = gnt;

    always_comb begin
        pkt_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                pkt_sel = in_data[i*PKT_W +: PKT_W];
            end
        end
    end

    always_comb begin
        hdr_word                 = '0;
        hdr_word[BUS_W-1 -: 8]   = SYNC_BYTE;
        hdr_word[7:0]            = {hdr_seq_q, ch_q};
    end

    // Bus outputs: framed words from registered state, or the legacy
    // combinational pass-through while in LOOP.
    always_comb begin
        ui_din       = '0;
        ui_din_be    = '0;
        ui_din_valid = 1'b0;
        ui_dout_get  = 1'b0;
        case (state_q)
            ST_HDR: begin
                ui_din_valid = 1'b1;
                ui_din       = hdr_word;
                ui_din_be    = '1;
            end
            ST_PAYLOAD: begin
                ui_din_valid = 1'b1;
                ui_din       = sh_q[SH_W-1 -: BUS_W];
                ui_din_be    = '1;
            end
            ST_LOOP: begin
                ui_dout_get  = !ui_din_full;
                ui_din_valid = !ui_dout_empty;
                ui_din       = ui_dout;
                ui_din_be    = ui_dout_be;
            end
            default: ;
        endcase
    end

    assign consume   = ui_din_valid && !ui_din_full;
    assign busy      = (state_q == ST_HDR) || (state_q == ST_PAYLOAD);
    assign pkt_count = pkt_q;

    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        hdr_seq_d = hdr_seq_q;
        ch_d      = ch_q;
        sh_d      = sh_q;
        wcnt_d    = wcnt_q;
        pkt_d     = pkt_q;
        case (state_q)
            ST_IDLE: begin
                if (!mode) begin
                    state_d = ST_LOOP;
                end else if (gnt_any) begin
                    state_d                = ST_HDR;
                    hdr_seq_d              = seq_q;
                    seq_d                  = seq_q + SEQ_W'(1);
                    ch_d                   = CH_FIELD_W'(gnt_idx);
                    sh_d                   = '0;
                    sh_d[SH_W-1 -: PKT_W]  = pkt_sel;
                end
            end
            ST_HDR: begin
                if (consume) begin
                    state_d = ST_PAYLOAD;
                    wcnt_d  = '0;
                end
            end
            ST_PAYLOAD: begin
                if (consume) begin
                    sh_d = sh_q << BUS_W;
                    if (wcnt_q == WCNT_W'(WORDS - 1)) begin
                        pkt_d   = pkt_q + 32'd1;
                        state_d = ST_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            ST_LOOP: begin
                if (mode) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_128M) begin
        if (rst_128M) begin
            state_q   <= ST_IDLE;
            seq_q     <= '0;
            hdr_seq_q <= '0;
            ch_q      <= '0;
            sh_q      <= '0;
            wcnt_q    <= '0;
            pkt_q     <= '0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            hdr_seq_q <= hdr_seq_d;
            ch_q      <= ch_d;
            sh_q      <= sh_d;
            wcnt_q    <= wcnt_d;
            pkt_q     <= pkt_d;
        end
    end

endmodule

// File: tb/tb_ft_telem_stream_mux.sv
module tb_ft_telem_stream_mux;

    localparam int NCH = 4;
    localparam int PW  = 88;

    logic             clk_128M = 1'b0;
    logic             rst_128M;
    logic             mode;
    logic [NCH*PW-1:0] in_data;
    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_ready;
    logic [15:0]      ui_dout;
    logic [1:0]       ui_dout_be;
    logic             ui_dout_empty;
    logic             ui_dout_get;
    logic [15:0]      ui_din;
    logic [1:0]       ui_din_be;
    logic             ui_din_valid;
    logic             ui_din_full;
    logic [31:0]      pkt_count;
    logic             busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_128M = ~clk_128M;

    ft_telem_stream_mux #(
        .NUM_CH    (NCH),
        .PKT_W     (PW),
        .BUS_W     (16),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk_128M      (clk_128M),
        .rst_128M      (rst_128M),
        .mode          (mode),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ui_dout       (ui_dout),
        .ui_dout_be    (ui_dout_be),
        .ui_dout_empty (ui_dout_empty),
        .ui_dout_get   (ui_dout_get),
        .ui_din        (ui_din),
        .ui_din_be     (ui_din_be),
        .ui_din_valid  (ui_din_valid),
        .ui_din_full   (ui_din_full),
        .pkt_count     (pkt_count),
        .busy          (busy)
    );

    typedef struct {
        logic [15:0] dout;
        logic [1:0]  be;
        logic        empty;
        logic        full;
        logic [15:0] x_din;
        logic [1:0]  x_be;
        logic        x_valid;
        logic        x_get;
    } lb_vec_t;

    lb_vec_t lb_tab [5];

    localparam logic [PW-1:0] PKT_A = 88'h0102030405060708090A0B;
    localparam logic [PW-1:0] PKT_B = 88'h1112131415161718191A1B;
    localparam logic [PW-1:0] PKT_C = 88'h2122232425262728292A2B;
    localparam logic [PW-1:0] PKT_D = 88'h3132333435363738393A3B;
    localparam logic [95:0]   WRD_A = 96'h0102_0304_0506_0708_090A_0B00;
    localparam logic [95:0]   WRD_B = 96'h1112_1314_1516_1718_191A_1B00;
    localparam logic [95:0]   WRD_C = 96'h2122_2324_2526_2728_292A_2B00;
    localparam logic [95:0]   WRD_D = 96'h3132_3334_3536_3738_393A_3B00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Leave the caller 2 time units after a rising edge.
    task automatic step();
        @(posedge clk_128M);
        #2;
    endtask

    // Entered in the cycle after the grant (header on the bus). Optionally
    // holds ui_din_full for stall_n cycles while word stall_idx is shown.
    task automatic run_frame(input logic [15:0] hdr, input logic [95:0] words,
                             input int stall_idx, input int stall_n, input string tag);
        logic [15:0] w;
        #1;
        chk({tag, " hdr"},       64'(ui_din), 64'(hdr));
        chk({tag, " hdr_valid"}, 64'(ui_din_valid), 64'd1);
        chk({tag, " hdr_be"},    64'(ui_din_be), 64'h3);
        chk({tag, " hdr_busy"},  64'(busy), 64'd1);
        chk({tag, " hdr_get"},   64'(ui_dout_get), 64'd0);
        chk({tag, " hdr_ready"}, 64'(in_ready), 64'd0);
        step();
        for (int k = 0; k < 6; k++) begin
            w = words[95-16*k -: 16];
            if (k == stall_idx) begin
                ui_din_full = 1'b1;
                for (int n = 0; n < stall_n; n++) begin
                    #1;
                    chk({tag, " stall_word"},  64'(ui_din), 64'(w));
                    chk({tag, " stall_valid"}, 64'(ui_din_valid), 64'd1);
                    step();
                end
                ui_din_full = 1'b0;
            end
            #1;
            chk({tag, " word"}, 64'(ui_din), 64'(w));
            step();
        end
    endtask

    initial begin
        lb_tab[0] = '{16'h1234, 2'b11, 1'b0, 1'b0, 16'h1234, 2'b11, 1'b1, 1'b1};
        lb_tab[1] = '{16'h5678, 2'b11, 1'b0, 1'b1, 16'h5678, 2'b11, 1'b1, 1'b0};
        lb_tab[2] = '{16'hABCD, 2'b01, 1'b1, 1'b0, 16'hABCD, 2'b01, 1'b0, 1'b1};
        lb_tab[3] = '{16'h0000, 2'b10, 1'b1, 1'b1, 16'h0000, 2'b10, 1'b0, 1'b0};
        lb_tab[4] = '{16'hFFFF, 2'b00, 1'b0, 1'b0, 16'hFFFF, 2'b00, 1'b1, 1'b1};

        rst_128M      = 1'b1;
        mode          = 1'b1;
        in_data       = '0;
        in_valid      = '0;
        ui_dout       = 16'h0;
        ui_dout_be    = 2'b00;
        ui_dout_empty = 1'b0;
        ui_din_full   = 1'b0;

        // Reset state
        step();
        step();
        #1;
        chk("rst in_ready",  64'(in_ready), 64'd0);
        chk("rst ui_din",    64'(ui_din), 64'd0);
        chk("rst ui_din_be", 64'(ui_din_be), 64'd0);
        chk("rst valid",     64'(ui_din_valid), 64'd0);
        chk("rst get",       64'(ui_dout_get), 64'd0);
        chk("rst pkt_count", 64'(pkt_count), 64'd0);
        chk("rst busy",      64'(busy), 64'd0);

        // Single ch0 packet
        rst_128M = 1'b0;
        in_data[0*PW +: PW] = PKT_A;
        in_valid = 4'b0001;
        #1;
        chk("t1 grant", 64'(in_ready), 64'h1);
        step();
        in_valid = '0;
        run_frame(16'hA500, WRD_A, -1, 0, "t1");
        #1;
        chk("t1 pkt_count", 64'(pkt_count), 64'd1);
        chk("t1 idle busy", 64'(busy), 64'd0);

        // ch1 and ch2 simultaneous after reset
        rst_128M = 1'b1;
        step();
        rst_128M = 1'b0;
        in_data[1*PW +: PW] = PKT_B;
        in_data[2*PW +: PW] = PKT_C;
        in_valid = 4'b0110;
        #1;
        chk("t2 grant ch1", 64'(in_ready), 64'h2);
        step();
        in_valid = 4'b0100;
        run_frame(16'hA501, WRD_B, -1, 0, "t2a");
        #1;
        chk("t2 grant ch2", 64'(in_ready), 64'h4);
        chk("t2 pkt_count a", 64'(pkt_count), 64'd1);
        step();
        in_valid = '0;
        run_frame(16'hA512, WRD_C, -1, 0, "t2b");
        #1;
        chk("t2 pkt_count b", 64'(pkt_count), 64'd2);

        // Backpressure on payload word 0506
        in_valid = 4'b0001;
        #1;
        chk("t3 grant", 64'(in_ready), 64'h1);
        step();
        in_valid = '0;
        run_frame(16'hA520, WRD_A, 2, 5, "t3");
        #1;
        chk("t3 pkt_count", 64'(pkt_count), 64'd3);

        // Loopback table
        mode    = 1'b0;
        ui_dout = 16'h1234;
        ui_dout_be = 2'b11;
        #1;
        chk("t4 idle get",   64'(ui_dout_get), 64'd0);
        chk("t4 idle valid", 64'(ui_din_valid), 64'd0);
        step();
        foreach (lb_tab[i]) begin
            ui_dout       = lb_tab[i].dout;
            ui_dout_be    = lb_tab[i].be;
            ui_dout_empty = lb_tab[i].empty;
            ui_din_full   = lb_tab[i].full;
            #1;
            chk("lb din",   64'(ui_din), 64'(lb_tab[i].x_din));
            chk("lb be",    64'(ui_din_be), 64'(lb_tab[i].x_be));
            chk("lb valid", 64'(ui_din_valid), 64'(lb_tab[i].x_valid));
            chk("lb get",   64'(ui_dout_get), 64'(lb_tab[i].x_get));
            chk("lb busy",  64'(busy), 64'd0);
            step();
        end
        ui_din_full   = 1'b0;
        ui_dout_empty = 1'b0;
        ui_dout       = 16'hCAFE;
        ui_dout_be    = 2'b11;
        mode          = 1'b1;
        #1;
        chk("lb exit din",   64'(ui_din), 64'hCAFE);
        chk("lb exit valid", 64'(ui_din_valid), 64'd1);
        chk("lb exit get",   64'(ui_dout_get), 64'd1);
        step();

        // Back in IDLE: host data ignored; ch3 granted; mode=0 mid-packet
        in_data[3*PW +: PW] = PKT_D;
        in_valid = 4'b1000;
        #1;
        chk("t5 idle valid", 64'(ui_din_valid), 64'd0);
        chk("t5 idle get",   64'(ui_dout_get), 64'd0);
        chk("t5 grant ch3",  64'(in_ready), 64'h8);
        step();
        in_valid = '0;
        mode     = 1'b0;
        run_frame(16'hA533, WRD_D, -1, 0, "t5");
        in_valid = 4'b0001;
        #1;
        chk("t5 pkt_count",  64'(pkt_count), 64'd4);
        chk("t5 no grant",   64'(in_ready), 64'd0);
        step();
        in_valid = '0;
        #1;
        chk("t5 loop get",   64'(ui_dout_get), 64'd1);
        chk("t5 loop valid", 64'(ui_din_valid), 64'd1);
        chk("t5 loop din",   64'(ui_din), 64'hCAFE);

        // Reset during payload word 0506
        mode = 1'b1;
        step();
        in_valid = 4'b0001;
        #1;
        chk("t6 grant", 64'(in_ready), 64'h1);
        step();
        #1;
        chk("t6 hdr", 64'(ui_din), 64'hA540);
        step();
        step();
        step();
        #1;
        chk("t6 word2", 64'(ui_din), 64'h0506);
        rst_128M = 1'b1;
        step();
        #1;
        chk("t6 rst in_ready",  64'(in_ready), 64'd0);
        chk("t6 rst ui_din",    64'(ui_din), 64'd0);
        chk("t6 rst be",        64'(ui_din_be), 64'd0);
        chk("t6 rst valid",     64'(ui_din_valid), 64'd0);
        chk("t6 rst get",       64'(ui_dout_get), 64'd0);
        chk("t6 rst pkt_count", 64'(pkt_count), 64'd0);
        chk("t6 rst busy",      64'(busy), 64'd0);
        rst_128M = 1'b0;
        #1;
        chk("t6 regrant", 64'(in_ready), 64'h1);
        step();
        in_valid = '0;
        run_frame(16'hA500, WRD_A, -1, 0, "t6");
        #1;
        chk("t6 pkt_count", 64'(pkt_count), 64'd1);

        // 17 back-to-back ch0 packets, seq wraps
        rst_128M = 1'b1;
        step();
        rst_128M = 1'b0;
        in_valid = 4'b0001;
        for (int k = 0; k < 17; k++) begin
            #1;
            chk("t7 grant", 64'(in_ready), 64'h1);
            step();
            run_frame({8'hA5, 4'(k), 4'h0}, WRD_A, -1, 0, "t7");
        end
        in_valid = '0;
        #1;
        chk("t7 pkt_count", 64'(pkt_count), 64'd17);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ft_telem_stream_mux.md
Name: ft_telem_stream_mux

Overview:
- Parametrised successor to the fixed FT loopback path in the top level.
- Arbitrates NUM_CH telemetry packet streams (already in the clk_128M domain) round-robin. Frames each packet with a sync/header word and serialises it into BUS_W-bit words on the ft ui_din interface.
- A run-time mode input selects between telemetry streaming and the legacy host loopback (ui_dout -> ui_din).
- Sits between gt_unpack_telemetry (via upstream CDC FIFOs) and the ft block.

Parameters:
- NUM_CH, 4, number of telemetry input channels (1..16).
- PKT_W, 88, bits per input packet.
- BUS_W, 16, ft bus width (multiple of 8, >=16).
- SYNC_BYTE, 8'hA5, constant in the header's top byte.

Ports:
- clk_128M  in  1  system clock.
- rst_128M  in  1  synchronous active-high reset.
- mode  in  1  0 = loopback, 1 = telemetry.
- in_data  in  NUM_CH*PKT_W  packet per channel; channel i at [i*PKT_W +: PKT_W].
- in_valid  in  NUM_CH  packet available per channel.
- in_ready  out  NUM_CH  one-hot accept pulse.
- ui_dout  in  BUS_W  host->FPGA data from ft.
- ui_dout_be  in  BUS_W/8  byte enables of ui_dout.
- ui_dout_empty  in  1  ft RX buffer empty.
- ui_dout_get  out  1  pop ft RX buffer.
- ui_din  out  BUS_W  FPGA->host data to ft.
- ui_din_be  out  BUS_W/8  byte enables of ui_din.
- ui_din_valid  out  1  ui_din holds a word.
- ui_din_full  in  1  ft TX buffer full.
- pkt_count  out  32  telemetry packets fully sent, wraps.
- busy  out  1  high in HDR or PAYLOAD.

Behaviour:
- Reset values: in_ready 0, ui_din 0, ui_din_be 0, ui_din_valid 0, ui_dout_get 0, pkt_count 0, busy 0.
- Reset internal state: state IDLE, seq 0, rr pointer NUM_CH-1 (so ch0 wins first).
- WORDS = ceil(PKT_W/BUS_W); 6 at defaults. Last word is zero-padded in its low bits.
- Header word: {SYNC_BYTE, seq[3:0], ch[3:0]}; bits between the top byte and the low byte are zero when BUS_W>16.
- seq: 4-bit global counter, +1 per packet granted, wraps 15->0.
- Transfer rule: a ui_din word is consumed in any cycle where ui_din_valid=1 and ui_din_full=0.
- While consumed is false, ui_din and ui_din_be hold stable. No drop, no duplication.
- States:
  - IDLE, mode=1: grant the first channel with in_valid set, searching upward from rr+1 and wrapping. in_ready[grant]=1 (combinational) that cycle. Latch packet into shift register, latch ch, set rr=ch. Next state HDR.
  - IDLE, no valid channel: stay in IDLE.
  - IDLE, mode=0: go to LOOP; no grant.
  - HDR: ui_din_valid=1, ui_din=header, be all ones. On consume -> PAYLOAD, word counter=0.
  - PAYLOAD: ui_din = top BUS_W bits of the shift register. On consume, shift left by BUS_W and increment the counter.
  - PAYLOAD end: on consume of word WORDS-1, pkt_count+1 and go to IDLE.
  - LOOP: combinational pass-through, identical to the legacy path:
    - ui_dout_get = !ui_din_full
    - ui_din_valid = !ui_dout_empty
    - ui_din = ui_dout
    - ui_din_be = ui_dout_be
  - LOOP, mode=1: go to IDLE next cycle; pass-through remains active in that cycle.
- In all states other than LOOP, ui_dout_get=0; host data is left in the ft buffer.
- Mode changes take effect only in IDLE or LOOP. A packet in progress always completes.
- Latency: grant at cycle t -> header valid at t+1. With no backpressure, one packet takes WORDS+2 cycles (8 at defaults).
- Reset mid-packet aborts the packet; the partial frame is lost, and the host resyncs on SYNC_BYTE. in_valid held by upstream is re-granted after reset.
- pkt_count wraps 2^32-1 -> 0.

Decomposition:
- Package ft_telem_pkg: SYNC_BYTE default, state encodings (IDLE, HDR, PAYLOAD, LOOP), WORDS computation function, header field widths.
- Sub-module rr_arbiter (NUM_CH request in, one-hot grant out, pointer update on accept), reusable elsewhere.

Test Plan:
- Reset, mode=1, ch0 valid with in_data[87:0]=88'h0102030405060708090A0B -> ui_din words A500, 0102, 0304, 0506, 0708, 090A, 0B00 on consecutive cycles; pkt_count=1; in_ready[0] high one cycle.
- ch1 and ch2 valid in the same cycle after reset -> ch1 sent first with header A501, then ch2 with header A512; ch2's in_ready pulses only after ch1's last word.
- ui_din_full high 5 cycles while payload word 3 is presented -> ui_din holds 0506 stable, and the frame completes with no lost or duplicated word.
- mode=0, host words 1234 then 5678 with be 11 -> same words appear on ui_din; ui_dout_get equals !ui_din_full.
- Setting mode=0 mid-packet -> the remaining words complete first, then LOOP.
- rst_128M asserted during payload word 3 -> next cycle all outputs are at reset values; after release, the next packet header has seq 0 and ch0 priority.
- 17 back-to-back ch0 packets -> headers A500..A5F0, then the 17th is A500; pkt_count=17.
